// File: rtl/z_event_window.sv
// z_event_window: counts rising edges of the detector output z over fixed
// windows of WINDOW enabled cycles and queues each window's count in a small
// result FIFO drained over a valid/ready handshake. A sticky flag records
// results dropped because the FIFO was full.
module z_event_window #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 5,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             z,
  input  logic             en,
  input  logic             res_ready,
  input  logic             clr_overrun,
  output logic [CNT_W-1:0] res_count,
  output logic             res_valid,
  output logic             res_overrun,
  output logic             busy
);

  localparam int WCNT_W = $clog2(WINDOW);
  localparam int PTR_W  = $clog2(DEPTH);

  localparam logic [WCNT_W-1:0] WLAST    = WCNT_W'(WINDOW - 1);
  localparam logic [PTR_W:0]    FULL_OCC = (PTR_W + 1)'(DEPTH);

  // Saturating increment of the edge count; holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             inc);
    if (inc && (c != {CNT_W{1'b1}})) begin
      return c + CNT_W'(1);
    end
    return c;
  endfunction

  logic              z_q;
  logic              z_rise;
  logic [WCNT_W-1:0] wcnt;
  logic [CNT_W-1:0]  ecnt;
  logic [CNT_W-1:0]  ecnt_next;
  logic              win_end;

  logic [CNT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    occ;
  logic              empty;
  logic              full;
  logic              pop;
  logic              accept;
  logic              drop;

  // Edge detection and the count this cycle's edge would produce.
  assign z_rise    = z & ~z_q;
  assign ecnt_next = sat_inc(ecnt, z_rise);
  assign win_end   = en && (wcnt == WLAST);

  // FIFO handshake: a pop frees a slot in the same cycle a full FIFO is pushed,
  // but an empty FIFO never bypasses the incoming result to the output.
  assign empty  = (occ == '0);
  assign full   = (occ == FULL_OCC);
  assign pop    = !empty && res_ready;
  assign accept = win_end && (!full || pop);
  assign drop   = win_end && full && !pop;

  assign res_valid = !empty;
  assign res_count = empty ? '0 : mem[rd_ptr];
  assign busy      = (wcnt != '0);

  // Previous z sample, taken every cycle independent of en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_q <= 1'b0;
    end else begin
      z_q <= z;
    end
  end

  // Window position and running edge count; disabling en discards the partial window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= '0;
      ecnt <= '0;
    end else if (!en) begin
      wcnt <= '0;
      ecnt <= '0;
    end else if (win_end) begin
      wcnt <= '0;
      ecnt <= '0;
    end else begin
      wcnt <= wcnt + WCNT_W'(1);
      ecnt <= ecnt_next;
    end
  end

  // Result storage; the entry written is the window's final saturated count.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= ecnt_next;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   occ <= occ + (PTR_W + 1)'(1);
        2'b01:   occ <= occ - (PTR_W + 1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Sticky overrun flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_overrun <= 1'b0;
    end else if (drop) begin
      res_overrun <= 1'b1;
    end else if (clr_overrun) begin
      res_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_z_event_window.sv
// Directed testbench for z_event_window: window counting, FIFO ordering,
// overrun handling, enable gating, asynchronous reset and count saturation.
module tb_z_event_window;

  logic       clk;
  logic       reset;
  logic       z;
  logic       en;
  logic       res_ready;
  logic       clr_overrun;
  logic [4:0] res_count;
  logic       res_valid;
  logic       res_overrun;
  logic       busy;
  logic [1:0] sat_count;
  logic       sat_valid;
  logic       sat_overrun;
  logic       sat_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  z_event_window #(.WINDOW(16), .CNT_W(5), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .z(z), .en(en), .res_ready(res_ready),
    .clr_overrun(clr_overrun), .res_count(res_count), .res_valid(res_valid),
    .res_overrun(res_overrun), .busy(busy)
  );

  z_event_window #(.WINDOW(16), .CNT_W(2), .DEPTH(4)) dut_sat (
    .clk(clk), .reset(reset), .z(z), .en(en), .res_ready(res_ready),
    .clr_overrun(clr_overrun), .res_count(sat_count), .res_valid(sat_valid),
    .res_overrun(sat_overrun), .busy(sat_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic zpat(input int n, input int i);
    return ((i % 2) == 1) && (i < 2 * n);
  endfunction

  task automatic step(input logic zv);
    z = zv;
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input int n);
    for (int i = 0; i < 16; i++) step(zpat(n, i));
  endtask

  task automatic do_reset();
    z = 1'b0; en = 1'b0; res_ready = 1'b0; clr_overrun = 1'b0;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    do_reset();
    total_cnt++;
    if (res_valid !== 1'b0) $display("FAIL rst_valid: got %0d expected 0", res_valid);
    else pass_cnt++;
    total_cnt++;
    if (res_count !== 5'd0) $display("FAIL rst_count: got %0d expected 0", res_count);
    else pass_cnt++;
    total_cnt++;
    if (res_overrun !== 1'b0) $display("FAIL rst_overrun: got %0d expected 0", res_overrun);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %0d expected 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_single_window();
    do_reset();
    en = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 15; i++) step(zpat(8, i));
    total_cnt++;
    if (res_valid !== 1'b0) $display("FAIL win_early_valid: got %0d expected 0", res_valid);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL win_busy: got %0d expected 1", busy);
    else pass_cnt++;
    step(zpat(8, 15));
    total_cnt++;
    if (res_valid !== 1'b1 || res_count !== 5'd8)
      $display("FAIL win_result: got valid=%0d count=%0d expected valid=1 count=8", res_valid, res_count);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL win_end_busy: got %0d expected 0", busy);
    else pass_cnt++;
    step(1'b0);
    total_cnt++;
    if (res_valid !== 1'b0) $display("FAIL win_pop: got valid=%0d expected 0", res_valid);
    else pass_cnt++;
  endtask

  task automatic test_held_high();
    do_reset();
    en = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step(1'b1);
      total_cnt++;
      if (busy !== (((i + 1) % 16) != 0))
        $display("FAIL held_busy[%0d]: got %0d expected %0d", i, busy, ((i + 1) % 16) != 0);
      else pass_cnt++;
      if (i == 15) begin
        total_cnt++;
        if (res_valid !== 1'b1 || res_count !== 5'd1)
          $display("FAIL held_first: got valid=%0d count=%0d expected valid=1 count=1", res_valid, res_count);
        else pass_cnt++;
      end
      if (i == 16) begin
        total_cnt++;
        if (res_valid !== 1'b0) $display("FAIL held_pop: got valid=%0d expected 0", res_valid);
        else pass_cnt++;
      end
      if (i == 31) begin
        total_cnt++;
        if (res_valid !== 1'b1 || res_count !== 5'd0)
          $display("FAIL held_second: got valid=%0d count=%0d expected valid=1 count=0", res_valid, res_count);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    en = 1'b1; res_ready = 1'b0;
    for (int w = 0; w < 4; w++) run_window(8);
    total_cnt++;
    if (res_valid !== 1'b1 || res_count !== 5'd8 || res_overrun !== 1'b0)
      $display("FAIL ovr_full: got valid=%0d count=%0d ovr=%0d expected 1/8/0", res_valid, res_count, res_overrun);
    else pass_cnt++;
    // Fifth window dropped while a clear is held: the set must win.
    clr_overrun = 1'b1;
    run_window(8);
    clr_overrun = 1'b0;
    total_cnt++;
    if (res_overrun !== 1'b1) $display("FAIL ovr_set: got %0d expected 1", res_overrun);
    else pass_cnt++;
    en = 1'b0; res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (res_valid !== 1'b1 || res_count !== 5'd8)
        $display("FAIL ovr_drain[%0d]: got valid=%0d count=%0d expected 1/8", k, res_valid, res_count);
      else pass_cnt++;
      step(1'b0);
    end
    total_cnt++;
    if (res_valid !== 1'b0 || res_overrun !== 1'b1)
      $display("FAIL ovr_empty: got valid=%0d ovr=%0d expected 0/1", res_valid, res_overrun);
    else pass_cnt++;
    clr_overrun = 1'b1;
    step(1'b0);
    clr_overrun = 1'b0;
    total_cnt++;
    if (res_overrun !== 1'b0) $display("FAIL ovr_clear: got %0d expected 0", res_overrun);
    else pass_cnt++;
  endtask

  task automatic test_enable_drop();
    do_reset();
    en = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 7; i++) step(zpat(3, i));
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL en_busy: got %0d expected 1", busy);
    else pass_cnt++;
    en = 1'b0;
    step(1'b0);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL en_idle: got %0d expected 0", busy);
    else pass_cnt++;
    for (int i = 0; i < 20; i++) step(1'b0);
    total_cnt++;
    if (res_valid !== 1'b0) $display("FAIL en_nopush: got valid=%0d expected 0", res_valid);
    else pass_cnt++;
    en = 1'b1;
    run_window(2);
    total_cnt++;
    if (res_valid !== 1'b1 || res_count !== 5'd2)
      $display("FAIL en_fresh: got valid=%0d count=%0d expected 1/2", res_valid, res_count);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; res_ready = 1'b0;
    for (int w = 0; w < 5; w++) run_window(3);
    for (int i = 0; i < 5; i++) step(zpat(3, i));
    total_cnt++;
    if (res_valid !== 1'b1 || res_overrun !== 1'b1 || busy !== 1'b1)
      $display("FAIL ar_pre: got valid=%0d ovr=%0d busy=%0d expected 1/1/1", res_valid, res_overrun, busy);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if (res_valid !== 1'b0 || res_overrun !== 1'b0 || busy !== 1'b0 || res_count !== 5'd0)
      $display("FAIL ar_now: got valid=%0d ovr=%0d busy=%0d count=%0d expected 0/0/0/0",
               res_valid, res_overrun, busy, res_count);
    else pass_cnt++;
    #2 reset = 1'b0;
    res_ready = 1'b1;
    run_window(6);
    total_cnt++;
    if (res_valid !== 1'b1 || res_count !== 5'd6)
      $display("FAIL ar_fresh: got valid=%0d count=%0d expected 1/6", res_valid, res_count);
    else pass_cnt++;
  endtask

  task automatic test_full_with_pop();
    do_reset();
    en = 1'b1; res_ready = 1'b0;
    for (int w = 1; w <= 4; w++) run_window(w);
    total_cnt++;
    if (res_valid !== 1'b1 || res_count !== 5'd1)
      $display("FAIL fp_head: got valid=%0d count=%0d expected 1/1", res_valid, res_count);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      res_ready = (i == 15);
      step(zpat(5, i));
    end
    res_ready = 1'b0;
    total_cnt++;
    if (res_valid !== 1'b1 || res_count !== 5'd2 || res_overrun !== 1'b0)
      $display("FAIL fp_swap: got valid=%0d count=%0d ovr=%0d expected 1/2/0", res_valid, res_count, res_overrun);
    else pass_cnt++;
    en = 1'b0; res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (res_valid !== 1'b1 || res_count !== 5'(k + 2))
        $display("FAIL fp_order[%0d]: got valid=%0d count=%0d expected 1/%0d", k, res_valid, res_count, k + 2);
      else pass_cnt++;
      step(1'b0);
    end
    total_cnt++;
    if (res_valid !== 1'b0) $display("FAIL fp_empty: got valid=%0d expected 0", res_valid);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_reset();
    en = 1'b1; res_ready = 1'b1;
    run_window(8);
    total_cnt++;
    if (sat_valid !== 1'b1 || sat_count !== 2'd3)
      $display("FAIL sat_clip: got valid=%0d count=%0d expected 1/3", sat_valid, sat_count);
    else pass_cnt++;
    run_window(2);
    total_cnt++;
    if (sat_valid !== 1'b1 || sat_count !== 2'd2)
      $display("FAIL sat_plain: got valid=%0d count=%0d expected 1/2", sat_valid, sat_count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_held_high();
    test_overrun();
    test_enable_drop();
    test_async_reset();
    test_full_with_pop();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
